// File: rtl/dma_bus_master_ci_if.sv
// System-bus signal bundle between the CI DMA engine (master) and the bus (slave side).
interface dma_bus_master_ci_if;
  logic        requestTransaction;
  logic        transactionGranted;
  logic        beginTransactionOut;
  logic [31:0] addressDataOut;
  logic        readNotWriteOut;
  logic [7:0]  burstSizeOut;
  logic [3:0]  byteEnablesOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busyIn;
  logic        errorIn;

  modport master (
    output requestTransaction,
    output beginTransactionOut,
    output addressDataOut,
    output readNotWriteOut,
    output burstSizeOut,
    output byteEnablesOut,
    output dataValidOut,
    output endTransactionOut,
    input  transactionGranted,
    input  addressDataIn,
    input  dataValidIn,
    input  endTransactionIn,
    input  busyIn,
    input  errorIn
  );

  modport slave (
    input  requestTransaction,
    input  beginTransactionOut,
    input  addressDataOut,
    input  readNotWriteOut,
    input  burstSizeOut,
    input  byteEnablesOut,
    input  dataValidOut,
    input  endTransactionOut,
    output transactionGranted,
    output addressDataIn,
    output dataValidIn,
    output endTransactionIn,
    output busyIn,
    output errorIn
  );
endinterface

// File: rtl/dma_bus_master_ci.sv
// Custom-instruction DMA engine: moves blocks between the local 512-word
// scratch buffer and shared memory in bursts, as a system-bus initiator.
module dma_bus_master_ci #(
  parameter logic [7:0] customId = 8'h00
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 ciN,
  input  logic [31:0]                valueA,
  input  logic [31:0]                valueB,
  output logic                       done,
  output logic [31:0]                result,
  dma_bus_master_ci_if.master        bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_BEGIN,
    ST_READ,
    ST_WRITE,
    ST_NEXT
  } state_t;

  state_t      state;

  logic [31:0] buffer [512];

  logic        ci_hit;
  logic        ci_we;
  logic [2:0]  ci_sel;
  logic [8:0]  ci_addr;
  logic [18:0] ci_unused;

  logic [31:0] bus_addr;
  logic [8:0]  buf_addr;
  logic [9:0]  block_len;
  logic [7:0]  burst_size;
  logic        error_flag;
  logic        dir_read;
  logic        busy;

  logic [8:0]  beat_cnt;
  logic [8:0]  pf_ptr;
  logic [31:0] pf_data;
  logic        pf_en;
  logic [8:0]  pf_addr;
  logic        dma_we;
  logic        cpu_we;

  logic [9:0]  burst_plus;
  logic [9:0]  burst_beats;
  logic [31:0] reg_rdata;

  logic        req_q;
  logic        begin_q;
  logic [31:0] ad_q;
  logic        rnw_q;
  logic [7:0]  bso_q;
  logic [3:0]  be_q;
  logic        dv_q;
  logic        end_q;

  assign ci_hit    = start && (ciN == customId);
  assign ci_sel    = valueA[12:10];
  assign ci_we     = valueA[9];
  assign ci_addr   = valueA[8:0];
  assign ci_unused = valueA[31:13];
  assign busy      = (state != ST_IDLE);

  assign bus.requestTransaction  = req_q;
  assign bus.beginTransactionOut = begin_q;
  assign bus.addressDataOut      = ad_q;
  assign bus.readNotWriteOut     = rnw_q;
  assign bus.burstSizeOut        = bso_q;
  assign bus.byteEnablesOut      = be_q;
  assign bus.dataValidOut        = dv_q;
  assign bus.endTransactionOut   = end_q;

  // Beats in the next burst and CI register readback mux.
  always_comb begin
    burst_plus  = {2'b00, burst_size} + 10'd1;
    burst_beats = (burst_plus < block_len) ? burst_plus : block_len;
    reg_rdata   = '0;
    case (ci_sel)
      3'd1:    reg_rdata = bus_addr;
      3'd2:    reg_rdata = {23'd0, buf_addr};
      3'd3:    reg_rdata = {22'd0, block_len};
      3'd4:    reg_rdata = {24'd0, burst_size};
      3'd5:    reg_rdata = {30'd0, error_flag, busy};
      default: reg_rdata = '0;
    endcase
  end

  // Buffer port control: incoming read beats take priority over a CPU write;
  // the prefetch read keeps one word ahead of the outgoing write beat.
  always_comb begin
    dma_we  = !reset && (state == ST_READ) && bus.dataValidIn && !bus.errorIn
              && (block_len != 10'd0);
    cpu_we  = !reset && ci_hit && ci_we && (ci_sel == 3'd0);
    pf_en   = ((state == ST_REQUEST) && bus.transactionGranted)
              || ((state == ST_BEGIN) && !dir_read)
              || ((state == ST_WRITE) && dv_q && !bus.busyIn && (beat_cnt != 9'd1));
    pf_addr = (state == ST_REQUEST) ? buf_addr : pf_ptr;
  end

  // Scratch buffer storage and prefetch register (never cleared by reset).
  always_ff @(posedge clock) begin
    if (dma_we) begin
      buffer[buf_addr] <= bus.addressDataIn;
    end else if (cpu_we) begin
      buffer[ci_addr] <= valueB;
    end
    if (pf_en) begin
      pf_data <= buffer[pf_addr];
    end
  end

  // CI response: one-cycle done pulse with result, zero otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= ci_hit;
      if (!ci_hit) begin
        result <= '0;
      end else if (ci_sel == 3'd0) begin
        result <= buffer[ci_addr];
      end else begin
        result <= reg_rdata;
      end
    end
  end

  // Transfer FSM with registered bus outputs; address, buffer pointer and
  // length advance per completed beat so an aborted transfer keeps its remainder.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      bus_addr   <= '0;
      buf_addr   <= '0;
      block_len  <= '0;
      burst_size <= '0;
      error_flag <= 1'b0;
      dir_read   <= 1'b0;
      beat_cnt   <= '0;
      pf_ptr     <= '0;
      req_q      <= 1'b0;
      begin_q    <= 1'b0;
      ad_q       <= '0;
      rnw_q      <= 1'b0;
      bso_q      <= '0;
      be_q       <= '0;
      dv_q       <= 1'b0;
      end_q      <= 1'b0;
    end else if (busy && bus.errorIn) begin
      state      <= ST_IDLE;
      error_flag <= 1'b1;
      req_q      <= 1'b0;
      begin_q    <= 1'b0;
      ad_q       <= '0;
      rnw_q      <= 1'b0;
      bso_q      <= '0;
      be_q       <= '0;
      dv_q       <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ci_hit && ci_we) begin
            case (ci_sel)
              3'd1: bus_addr   <= {valueB[31:2], 2'b00};
              3'd2: buf_addr   <= valueB[8:0];
              3'd3: block_len  <= valueB[9:0];
              3'd4: burst_size <= valueB[7:0];
              3'd5: begin
                if (valueB[0] || valueB[1]) begin
                  error_flag <= 1'b0;
                  dir_read   <= valueB[0];
                  if (block_len != 10'd0) begin
                    state <= ST_REQUEST;
                    req_q <= 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        ST_REQUEST: begin
          if (bus.transactionGranted) begin
            state    <= ST_BEGIN;
            begin_q  <= 1'b1;
            ad_q     <= bus_addr;
            bso_q    <= 8'(burst_beats - 10'd1);
            be_q     <= 4'hF;
            rnw_q    <= dir_read;
            beat_cnt <= 9'(burst_beats);
            pf_ptr   <= buf_addr + 9'd1;
          end
        end
        ST_BEGIN: begin
          begin_q <= 1'b0;
          be_q    <= '0;
          bso_q   <= '0;
          if (dir_read) begin
            ad_q  <= '0;
            state <= ST_READ;
          end else begin
            ad_q   <= pf_data;
            dv_q   <= 1'b1;
            pf_ptr <= pf_ptr + 9'd1;
            state  <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (bus.dataValidIn && (block_len != 10'd0)) begin
            buf_addr  <= buf_addr + 9'd1;
            block_len <= block_len - 10'd1;
            bus_addr  <= bus_addr + 32'd4;
          end
          if (bus.endTransactionIn) begin
            req_q <= 1'b0;
            rnw_q <= 1'b0;
            state <= ST_NEXT;
          end
        end
        ST_WRITE: begin
          if (end_q) begin
            end_q <= 1'b0;
            req_q <= 1'b0;
            state <= ST_NEXT;
          end else if (dv_q && !bus.busyIn) begin
            buf_addr  <= buf_addr + 9'd1;
            block_len <= block_len - 10'd1;
            bus_addr  <= bus_addr + 32'd4;
            beat_cnt  <= beat_cnt - 9'd1;
            if (beat_cnt == 9'd1) begin
              dv_q  <= 1'b0;
              ad_q  <= '0;
              end_q <= 1'b1;
            end else begin
              ad_q   <= pf_data;
              pf_ptr <= pf_ptr + 9'd1;
            end
          end
        end
        ST_NEXT: begin
          if (block_len != 10'd0) begin
            req_q <= 1'b1;
            state <= ST_REQUEST;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_bus_master_ci.sv
// Directed and randomized bench for dma_bus_master_ci with a word-array
// model of the scratch buffer and burst arithmetic derived from block rules.
module tb_dma_bus_master_ci;
  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  dma_bus_master_ci_if bus_if ();

  dma_bus_master_ci #(.customId(8'h00)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .ciN    (ciN),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result),
    .bus    (bus_if)
  );

  int unsigned n_pass;
  int unsigned n_fail;
  int unsigned n_total;
  logic [31:0] ref_buf [512];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bus_outs();
    return {15'd0, bus_if.requestTransaction, bus_if.beginTransactionOut,
            bus_if.addressDataOut, bus_if.readNotWriteOut, bus_if.burstSizeOut,
            bus_if.byteEnablesOut, bus_if.dataValidOut, bus_if.endTransactionOut};
  endfunction

  task automatic ci(input logic [2:0] sel, input logic we, input logic [8:0] addr,
                    input logic [31:0] data, output logic [31:0] rd);
    start  = 1'b1;
    ciN    = 8'h00;
    valueA = {19'($urandom), sel, we, addr};
    valueB = data;
    tick();
    start  = 1'b0;
    ciN    = 8'($urandom);
    valueA = $urandom;
    valueB = $urandom;
    check("ci_done", done, 1);
    rd = result;
  endtask

  task automatic wait_req();
    int unsigned n;
    n = 0;
    while (bus_if.requestTransaction !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check("req_raised", bus_if.requestTransaction, 1);
  endtask

  task automatic transfer(input bit rd_dir, input logic [31:0] bus_a, input logic [8:0] buf_a,
                          input int unsigned len, input int unsigned burst,
                          input int unsigned mode, input bit poke);
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] w;
    int unsigned rem, beats, k, cyc, stall_left, b, b0;
    bit first, busy;
    ci(3'd1, 1'b1, 9'd0, bus_a, d);
    ci(3'd2, 1'b1, 9'd0, {23'd0, buf_a}, d);
    ci(3'd3, 1'b1, 9'd0, 32'(len), d);
    ci(3'd4, 1'b1, 9'd0, 32'(burst), d);
    ci(3'd5, 1'b1, 9'd0, rd_dir ? (($urandom_range(0, 1) == 1) ? 32'd3 : 32'd1) : 32'd2, d);
    rem   = len;
    a     = bus_a & 32'hFFFF_FFFC;
    b     = buf_a;
    b0    = b;
    first = 1'b1;
    while (rem != 0) begin
      beats = (burst + 1 < rem) ? burst + 1 : rem;
      wait_req();
      if (bus_if.requestTransaction !== 1'b1) return;
      if (first && poke) begin
        ci(3'd5, 1'b1, 9'd0, rd_dir ? 32'd2 : 32'd1, d);
        ci(3'd1, 1'b1, 9'd0, 32'hFFFF_0000, d);
        ci(3'd5, 1'b0, 9'd0, 32'd0, d);
        check("busy_status", d, 1);
      end
      first = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("req_held", bus_if.requestTransaction, 1);
      end
      bus_if.transactionGranted = 1'b1;
      tick();
      bus_if.transactionGranted = 1'b0;
      check("begin_pulse", bus_if.beginTransactionOut, 1);
      check("begin_addr", bus_if.addressDataOut, a);
      check("begin_burst", bus_if.burstSizeOut, beats - 1);
      check("begin_rnw", bus_if.readNotWriteOut, rd_dir);
      check("begin_be", bus_if.byteEnablesOut, 4'hF);
      tick();
      check("begin_single", {bus_if.beginTransactionOut, bus_if.byteEnablesOut}, 0);
      if (rd_dir) begin
        for (k = 0; k < beats; k++) begin
          if (mode != 0) repeat ($urandom_range(0, 2)) tick();
          w = $urandom;
          bus_if.dataValidIn      = 1'b1;
          bus_if.addressDataIn    = w;
          bus_if.endTransactionIn = (k == beats - 1);
          ref_buf[b] = w;
          b = (b + 1) % 512;
          tick();
          bus_if.dataValidIn      = 1'b0;
          bus_if.endTransactionIn = 1'b0;
          bus_if.addressDataIn    = $urandom;
        end
      end else begin
        k = 0;
        cyc = 0;
        stall_left = (mode == 2) ? 2 : 0;
        while (k < beats && cyc < 2000) begin
          check("wr_valid", bus_if.dataValidOut, 1);
          check("wr_data", bus_if.addressDataOut, ref_buf[b]);
          if (mode == 2) busy = (k == 1 && stall_left != 0);
          else if (mode == 1) busy = ($urandom_range(0, 3) == 0);
          else busy = 1'b0;
          if (busy && mode == 2) stall_left--;
          bus_if.busyIn = busy;
          tick();
          if (!busy) begin
            k++;
            b = (b + 1) % 512;
          end
          cyc++;
        end
        bus_if.busyIn = 1'b0;
        check("wr_beats", k, beats);
        check("wr_end", {bus_if.endTransactionOut, bus_if.dataValidOut}, 2'b10);
        tick();
        check("wr_end_single", bus_if.endTransactionOut, 0);
      end
      a   = a + 32'(4 * beats);
      rem = rem - beats;
    end
    repeat (2) tick();
    ci(3'd5, 1'b0, 9'd0, 32'd0, d);
    check("status_idle", d, 0);
    if (rd_dir) begin
      for (int unsigned i = 0; i < len; i++) begin
        ci(3'd0, 1'b0, 9'((b0 + i) % 512), 32'd0, d);
        check("rd_landed", d, ref_buf[(b0 + i) % 512]);
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] w;
    n_pass  = 0;
    n_fail  = 0;
    n_total = 0;
    reset  = 1'b1;
    start  = 1'b0;
    ciN    = 8'h00;
    valueA = '0;
    valueB = '0;
    bus_if.transactionGranted = 1'b0;
    bus_if.addressDataIn      = '0;
    bus_if.dataValidIn        = 1'b0;
    bus_if.endTransactionIn   = 1'b0;
    bus_if.busyIn             = 1'b0;
    bus_if.errorIn            = 1'b0;
    repeat (2) tick();
    check("reset_bus_outs", bus_outs(), 0);
    check("reset_ci", {done, result}, 0);
    reset = 1'b0;
    tick();

    for (int unsigned i = 0; i < 512; i++) begin
      w = $urandom;
      ref_buf[i] = w;
      ci(3'd0, 1'b1, 9'(i), w, d);
    end

    // Buffer access through the CI path.
    ci(3'd0, 1'b1, 9'd5, 32'hDEADBEEF, d);
    ref_buf[5] = 32'hDEADBEEF;
    ci(3'd0, 1'b0, 9'd5, 32'd0, d);
    check("buf_read", d, 32'hDEADBEEF);
    tick();
    check("done_low_after", {done, result}, 0);
    start  = 1'b1;
    ciN    = 8'h5A;
    valueA = {19'd0, 3'd0, 1'b1, 9'd5};
    valueB = 32'h0;
    tick();
    start = 1'b0;
    check("other_ci_ignored", done, 0);
    ci(3'd0, 1'b0, 9'd5, 32'd0, d);
    check("buf_kept", d, 32'hDEADBEEF);

    // Register readback rules.
    ci(3'd1, 1'b1, 9'd0, 32'h12345677, d);
    ci(3'd1, 1'b0, 9'd0, 32'd0, d);
    check("bus_addr_aligned", d, 32'h12345674);
    ci(3'd2, 1'b1, 9'd0, 32'hFFFF_FFFF, d);
    ci(3'd2, 1'b0, 9'd0, 32'd0, d);
    check("buf_addr_9bit", d, 32'h1FF);
    ci(3'd6, 1'b1, 9'd0, 32'hFFFF_FFFF, d);
    ci(3'd6, 1'b0, 9'd0, 32'd0, d);
    check("reserved_sel", d, 0);

    // Wrapping read transfer in two bursts, then a stalled single-burst write.
    transfer(1'b1, 32'h0000_1000, 9'd510, 4, 1, 0, 1'b0);
    transfer(1'b0, 32'h0000_4000, 9'd40, 3, 7, 2, 1'b0);

    // Bus error on the second beat of a four-word read.
    ci(3'd1, 1'b1, 9'd0, 32'h0000_2000, d);
    ci(3'd2, 1'b1, 9'd0, 32'd20, d);
    ci(3'd3, 1'b1, 9'd0, 32'd4, d);
    ci(3'd4, 1'b1, 9'd0, 32'd3, d);
    ci(3'd5, 1'b1, 9'd0, 32'd1, d);
    wait_req();
    bus_if.transactionGranted = 1'b1;
    tick();
    bus_if.transactionGranted = 1'b0;
    check("err_begin_burst", bus_if.burstSizeOut, 3);
    tick();
    w = $urandom;
    bus_if.dataValidIn   = 1'b1;
    bus_if.addressDataIn = w;
    ref_buf[20] = w;
    tick();
    bus_if.addressDataIn = $urandom;
    bus_if.errorIn       = 1'b1;
    tick();
    bus_if.dataValidIn = 1'b0;
    bus_if.errorIn     = 1'b0;
    check("err_bus_outs", bus_outs(), 0);
    ci(3'd5, 1'b0, 9'd0, 32'd0, d);
    check("err_status", d, 32'h2);
    ci(3'd0, 1'b0, 9'd20, 32'd0, d);
    check("err_first_beat", d, ref_buf[20]);

    // Zero-length start: accepted, clears error, no bus activity.
    ci(3'd3, 1'b1, 9'd0, 32'd0, d);
    ci(3'd5, 1'b1, 9'd0, 32'd1, d);
    repeat (4) begin
      check("len0_no_req", bus_if.requestTransaction, 0);
      tick();
    end
    ci(3'd5, 1'b0, 9'd0, 32'd0, d);
    check("len0_status", d, 0);

    // Start and register writes while busy are ignored.
    transfer(1'b1, 32'h0000_3000, 9'd200, 6, 2, 1, 1'b1);

    // Randomized transfers, including a full-buffer write.
    for (int i = 0; i < 6; i++) begin
      transfer(1'($urandom_range(0, 1)), $urandom, 9'($urandom), $urandom_range(1, 24),
               $urandom_range(0, 9), 1, 1'b0);
    end
    transfer(1'b0, $urandom, 9'd300, 512, 255, 1, 1'b0);

    // Reset in the middle of a write burst.
    ci(3'd1, 1'b1, 9'd0, 32'h0000_8000, d);
    ci(3'd2, 1'b1, 9'd0, 32'd100, d);
    ci(3'd3, 1'b1, 9'd0, 32'd8, d);
    ci(3'd4, 1'b1, 9'd0, 32'd7, d);
    ci(3'd5, 1'b1, 9'd0, 32'd2, d);
    wait_req();
    bus_if.transactionGranted = 1'b1;
    tick();
    bus_if.transactionGranted = 1'b0;
    tick();
    check("rst_beat0", bus_if.addressDataOut, ref_buf[100]);
    tick();
    check("rst_beat1", bus_if.addressDataOut, ref_buf[101]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_bus_outs", bus_outs(), 0);
    repeat (4) begin
      tick();
      check("rst_quiet", {bus_if.requestTransaction, bus_if.dataValidOut}, 0);
    end
    ci(3'd5, 1'b0, 9'd0, 32'd0, d);
    check("rst_status", d, 0);
    ci(3'd3, 1'b0, 9'd0, 32'd0, d);
    check("rst_len_cleared", d, 0);
    ci(3'd0, 1'b0, 9'd100, 32'd0, d);
    check("rst_buf_kept", d, ref_buf[100]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
